// File: rtl/memory_unit.sv
// Wait-stated single-port 16-bit word memory with a req/ack bus slave interface.
// Optional burst transfers are enabled by defining MEMORY_UNIT_BURST_EN.
module memory_unit #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        r,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
`ifdef MEMORY_UNIT_BURST_EN
    input  logic [3:0]  blen,
`endif
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    // Handshake: a request is taken only when req=1 on an edge while idle (busy=0);
    // ack is a one-cycle pulse per word and err is meaningful only while ack=1.
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wr_data;
    logic        in_range;
    logic        last_beat;
    logic [15:0] mem [DEPTH];

`ifdef MEMORY_UNIT_BURST_EN
    // beats_q counts the beats still to go after the current one.
    logic [3:0]  beats_q;
    assign last_beat = (beats_q == 4'd0);
    assign wr_data   = wdata;
`else
    logic [15:0] wdata_q;
    assign last_beat = 1'b1;
    assign wr_data   = wdata_q;
`endif

    assign in_range = ((addr_q >> ADDR_W) == 16'd0);

    always_ff @(posedge clk) begin
        if (r) state <= S_IDLE;
        else   state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (req) state_nx = (WAIT_CNT == 4'd0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt <= 4'd1) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_DONE;
            S_DONE:   state_nx = last_beat ? S_IDLE : S_ACCESS;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            rdata <= 16'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            ack <= (state == S_ACCESS);
            err <= (state == S_ACCESS) && !in_range;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        addr_q <= addr;
                        cnt    <= WAIT_CNT;
`ifdef MEMORY_UNIT_BURST_EN
                        beats_q <= blen;
`else
                        wdata_q <= wdata;
`endif
                    end
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_ACCESS: begin
                    if (!we_q) rdata <= in_range ? mem[addr_q[ADDR_W-1:0]] : 16'd0;
                end
                S_DONE: begin
`ifdef MEMORY_UNIT_BURST_EN
                    if (!last_beat) begin
                        addr_q  <= addr_q + 16'd1;
                        beats_q <= beats_q - 4'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared; a reset at the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!r && state == S_ACCESS && we_q && in_range)
            mem[addr_q[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: word-address width, giving a depth of 2^ADDR_W 16-bit words.
REQ-002 SHALL have parameter WAIT, default 2: wait-state cycles inserted before each access (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port r  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  transfer request from the bus master.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  16  word address; sampled with req.
REQ-008 SHALL have port wdata  input  16  write data; sampled with req.
REQ-009 SHALL have port rdata  output  16  read data, registered.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse per word.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port err  output  1  out-of-range flag; valid only while ack is high.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT, ACCESS and DONE.
REQ-014 SHALL, in IDLE with req=1 at edge N, latch we/addr/wdata, load the wait counter with WAIT, and go to WAIT (or straight to ACCESS if WAIT=0); req outside IDLE SHALL be ignored.
REQ-015 SHALL, in WAIT, decrement the counter each edge and go to ACCESS after exactly WAIT cycles.
REQ-016 SHALL, in ACCESS, perform the memory write or read on that edge, register ack=1 and err, update rdata on reads, and go to DONE; ack is therefore high in cycle N+WAIT+2.
REQ-017 SHALL, in DONE, clear ack at the next edge and return to IDLE; with req held high, the next transfer is accepted on the following IDLE edge, so back-to-back transfers have a period of WAIT+3 cycles.
REQ-018 SHALL treat an address as out of range when addr[15:ADDR_W] != 0: such a write SHALL not modify memory, such a read SHALL set rdata=0, and err=1 SHALL accompany ack.
REQ-019 SHALL leave rdata unchanged by writes and hold it until the next completed read.
REQ-020 SHALL ensure a write followed by a read of the same address returns the written data, with no stale value.

Reset
REQ-021 SHALL, at any edge with r=1, set the state to IDLE and rdata=0, ack=0, busy=0, err=0 and the wait counter to 0.
REQ-022 SHALL make r take priority over req at the same edge, so that no request is accepted.
REQ-023 SHALL abort an in-flight transfer on reset without a memory write; memory contents are not cleared by r.

Configuration
REQ-024 SHALL, when macro MEMORY_UNIT_BURST_EN is defined, add port blen (input, 4 bits, sampled with req) and perform blen+1 word transfers at addresses addr, addr+1, ... (16-bit wrap).
REQ-025 SHALL, under MEMORY_UNIT_BURST_EN, insert wait states only before the first beat, then alternate ACCESS/DONE for each beat with one ack per beat, and sample wdata at each write-beat ACCESS edge.
REQ-026 SHALL, under MEMORY_UNIT_BURST_EN, evaluate err per beat and return to IDLE after the final beat's DONE.
REQ-027 SHALL, without MEMORY_UNIT_BURST_EN, omit the blen port and behave per REQ-013..REQ-020 with single-word transfers only.

Verification (WAIT=2, ADDR_W=8)
REQ-028 Write 0xBEEF to 0x0010, then read 0x0010 -> ack at cycle N+4 of each transfer, rdata=0xBEEF, err=0.
REQ-029 Read of 0x0100 -> ack with err=1 and rdata=0x0000; a following read of 0x0000 shows its memory value unchanged.
REQ-030 Assert r during WAIT of a write to 0x0005 -> next cycle busy=0, ack=0; a read of 0x0005 returns the previous value.
REQ-031 Hold req=1 with r=1, then release r -> no ack during reset; the first transfer is accepted on the first edge with r=0.
REQ-032 req held high with alternating addresses 0x0001/0x0002 -> acks spaced exactly 5 cycles apart; req pulses during busy create no extra acks.
REQ-033 With MEMORY_UNIT_BURST_EN: burst write of blen=3 at 0x00FE with data 1..4 -> 4 acks, beats at 0x00FE/0x00FF with err=0 and at 0x0100/0x0101 with err=1; a read-back burst returns 1, 2, 0, 0.
